// File: rtl/cs_sched_pkg.sv
// Shared types and width helpers for the checksum request scheduler.
package cs_sched_pkg;

  localparam int DW = 512;
  localparam int RW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cs_req_sched_if.sv
// Requester-side bundle: request handshake plus tagged response strobe.
interface cs_req_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = cs_sched_pkg::DW,
  parameter int RES_W   = cs_sched_pkg::RW,
  parameter int ID_W    = cs_sched_pkg::id_width(NUM_REQ)
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      resp_valid;
  logic [ID_W-1:0]           resp_id;
  logic [RES_W-1:0]          resp_result;
  logic                      resp_err;

  modport master (
    output req_valid, req_data,
    input  req_ready, resp_valid, resp_id, resp_result, resp_err
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, resp_valid, resp_id, resp_result, resp_err
  );

endinterface

// File: rtl/cs_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr_i, with wrap.
module cs_rr_arb #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] id_o,
  output logic           any_o
);

  always_comb begin
    int idx;
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/cs_req_sched.sv
// Shares one CS instance among NUM_REQ requesters: RR grant, one-cycle issue, timed wait, tagged reply.
// Optional saturating done/timeout counters under CS_SCHED_STAT_EN.
module cs_req_sched
  import cs_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int WIDTH_DATA_1   = 384,
  parameter int WIDTH_DATA_2   = 128,
  parameter int WIDTH_RESULT_1 = 8,
  parameter int WIDTH_RESULT_2 = 8,
  parameter int TIMEOUT_CYC    = 1023,
  localparam int DATA_W = WIDTH_DATA_1 + WIDTH_DATA_2,
  localparam int RES_W  = WIDTH_RESULT_1 + WIDTH_RESULT_2,
  localparam int IDW    = id_width(NUM_REQ),
  localparam int CNT_W  = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic              clk,
  input  logic              rst,
  cs_req_sched_if.slave     req_if,
  output logic              cs_in_valid,
  output logic [DATA_W-1:0] cs_data,
  input  logic              cs_out_valid,
  input  logic [RES_W-1:0]  cs_result,
  output logic              busy
`ifdef CS_SCHED_STAT_EN
  ,
  output logic [15:0]       stat_done,
  output logic [15:0]       stat_timeout
`endif
);

  state_t             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     cur_id_q, cur_id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [RES_W-1:0]   result_q, result_d;
  logic               err_q, err_d;

  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     arb_id;
  logic               arb_any;

  cs_rr_arb #(.N(NUM_REQ), .IDW(IDW)) u_arb (
    .req_i (req_if.req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt),
    .id_o  (arb_id),
    .any_o (arb_any)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_id_d = cur_id_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (arb_any) begin
          data_d   = req_if.req_data[int'(arb_id)*DATA_W +: DATA_W];
          cur_id_d = arb_id;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // A response landing on the timeout cycle still counts as success.
        if (cs_out_valid) begin
          result_d = cs_result;
          err_d    = 1'b0;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        rr_ptr_d = (cur_id_q == IDW'(NUM_REQ - 1)) ? '0 : cur_id_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      cur_id_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      cur_id_q <= cur_id_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign req_if.req_ready   = (state_q == IDLE) ? gnt : '0;
  assign req_if.resp_valid  = (state_q == RESP);
  assign req_if.resp_id     = cur_id_q;
  assign req_if.resp_result = result_q;
  assign req_if.resp_err    = err_q;
  assign cs_in_valid        = (state_q == ISSUE);
  assign cs_data            = data_q;
  assign busy               = (state_q != IDLE);

`ifdef CS_SCHED_STAT_EN
  logic [15:0] stat_done_q, stat_timeout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_done_q    <= '0;
      stat_timeout_q <= '0;
    end else if (state_q == RESP) begin
      if (err_q && stat_timeout_q != 16'hFFFF) stat_timeout_q <= stat_timeout_q + 16'd1;
      if (!err_q && stat_done_q != 16'hFFFF) stat_done_q <= stat_done_q + 16'd1;
    end
  end

  assign stat_done    = stat_done_q;
  assign stat_timeout = stat_timeout_q;
`endif

endmodule

// File: tb/tb_cs_req_sched.sv
// Directed plus randomized bench for cs_req_sched with a behavioural CS responder and RR reference.
module tb_cs_req_sched;

  localparam int N    = 4;
  localparam int DW_T = 512;
  localparam int RW_T = 16;
  localparam int IW_T = 2;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cs_req_sched_if #(.NUM_REQ(N), .DATA_W(DW_T), .RES_W(RW_T), .ID_W(IW_T)) rif ();

  logic            cs_in_valid;
  logic [DW_T-1:0] cs_data;
  logic            cs_out_valid;
  logic [RW_T-1:0] cs_result;
  logic            busy;
`ifdef CS_SCHED_STAT_EN
  logic [15:0]     stat_done, stat_timeout;
`endif

  cs_req_sched #(.NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_if       (rif),
    .cs_in_valid  (cs_in_valid),
    .cs_data      (cs_data),
    .cs_out_valid (cs_out_valid),
    .cs_result    (cs_result),
    .busy         (busy)
`ifdef CS_SCHED_STAT_EN
    ,
    .stat_done    (stat_done),
    .stat_timeout (stat_timeout)
`endif
  );

  function automatic logic [15:0] csum(input logic [511:0] d);
    logic [15:0] s;
    s = '0;
    for (int i = 0; i < 32; i++) s = s + d[i*16 +: 16];
    return s;
  endfunction

  // CS stand-in: answers cs_lat cycles after in_valid unless silenced.
  int           cs_lat    = 3;
  bit           cs_silent = 1'b0;
  bit           inj_ov    = 1'b0;
  bit           mdl_ov    = 1'b0;
  bit           mdl_busy  = 1'b0;
  int           mdl_cnt   = 0;
  logic [15:0]  mdl_res   = '0;
  logic [511:0] mdl_dat   = '0;

  assign cs_out_valid = mdl_ov | inj_ov;
  assign cs_result    = inj_ov ? 16'hDEAD : mdl_res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mdl_ov   <= 1'b0;
      mdl_busy <= 1'b0;
      mdl_cnt  <= 0;
    end else begin
      mdl_ov <= 1'b0;
      if (mdl_busy) begin
        if (mdl_cnt <= 1) begin
          mdl_ov   <= 1'b1;
          mdl_res  <= csum(mdl_dat);
          mdl_busy <= 1'b0;
        end else begin
          mdl_cnt <= mdl_cnt - 1;
        end
      end
      if (cs_in_valid && !cs_silent) begin
        if (cs_lat <= 1) begin
          mdl_ov  <= 1'b1;
          mdl_res <= csum(cs_data);
        end else begin
          mdl_busy <= 1'b1;
          mdl_cnt  <= cs_lat - 1;
          mdl_dat  <= cs_data;
        end
      end
    end
  end

  int           n_chk  = 0;
  int           n_fail = 0;
  int           cyc    = 0;
  int           ptr_m  = 0;
  bit [N-1:0]   pend   = '0;
  logic [511:0] rdat [N];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  task automatic set_req(input int id, input logic [511:0] d);
    rif.req_data[id*DW_T +: DW_T] = d;
    rif.req_valid[id] = 1'b1;
    rdat[id] = d;
    pend[id] = 1'b1;
  endtask

  // Winner = pending requester closest to the pointer going upward (mod N).
  function automatic int rr_pick(input bit [N-1:0] m, input int p);
    int best;
    best = -1;
    for (int id = 0; id < N; id++)
      if (m[id] && (best < 0 || ((id - p + N) % N) < ((best - p + N) % N))) best = id;
    return best;
  endfunction

  task automatic do_txn(input bit keep, input bit exp_err, input bit inj_issue);
    int id, t0;
    logic [511:0] d;
    #1;
    id = rr_pick(pend, ptr_m);
    check("req_ready_grant", rif.req_ready, 1 << id);
    d  = rdat[id];
    t0 = cyc;
    tick();
    if (!keep) begin
      rif.req_valid[id] = 1'b0;
      pend[id] = 1'b0;
    end
    if (inj_issue) inj_ov = 1'b1;
    check("cs_in_valid_issue", cs_in_valid, 1);
    check("cs_data", cs_data, d);
    check("req_ready_busy", rif.req_ready, 0);
    tick();
    inj_ov = 1'b0;
    check("cs_in_valid_pulse", cs_in_valid, 0);
    for (int i = 0; i < TO + 10 && rif.resp_valid !== 1'b1; i++) tick();
    check("resp_latency", cyc - t0, exp_err ? TO + 2 : cs_lat + 2);
    check("resp_id", rif.resp_id, id);
    check("resp_result", rif.resp_result, exp_err ? 16'h0 : csum(d));
    check("resp_err", rif.resp_err, exp_err);
    ptr_m = (id + 1) % N;
    tick();
    check("resp_pulse", rif.resp_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rif.req_valid = '0;
    pend  = '0;
    ptr_m = 0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rif.req_valid = '0;
    rif.req_data  = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_cs_in_valid", cs_in_valid, 0);
    check("rst_cs_data", cs_data, 0);
    check("rst_resp_valid", rif.resp_valid, 0);
    check("rst_resp_id", rif.resp_id, 0);
    check("rst_resp_result", rif.resp_result, 0);
    check("rst_resp_err", rif.resp_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();

    cs_lat = 3;
    set_req(2, {64{8'hA5}});
    do_txn(1'b0, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < N; i++) set_req(i, rand_data());
    for (int i = 0; i < N; i++) begin
      cs_lat = int'($urandom_range(1, 4));
      do_txn(1'b0, 1'b0, 1'b0);
    end
    check("all_served_idle", busy, 0);

    set_req(0, rand_data());
    set_req(3, rand_data());
    for (int i = 0; i < 8; i++) do_txn(1'b1, 1'b0, 1'b0);
    rif.req_valid = '0;
    pend = '0;

    cs_silent = 1'b1;
    set_req(1, rand_data());
    do_txn(1'b0, 1'b1, 1'b0);
    cs_silent = 1'b0;
    cs_lat = 2;
    set_req(2, rand_data());
    do_txn(1'b0, 1'b0, 1'b0);

    inj_ov = 1'b1;
    tick();
    inj_ov = 1'b0;
    check("idle_ov_no_resp", rif.resp_valid, 0);
    check("idle_ov_busy", busy, 0);
    tick();
    check("idle_ov_no_resp2", rif.resp_valid, 0);
    cs_lat = 4;
    set_req(0, rand_data());
    do_txn(1'b0, 1'b0, 1'b1);

    cs_lat = 10;
    set_req(1, rand_data());
    #1;
    check("abort_grant", rif.req_ready, 2);
    tick();
    rif.req_valid[1] = 1'b0;
    pend[1] = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_resp_valid", rif.resp_valid, 0);
    check("arst_cs_in_valid", cs_in_valid, 0);
    check("arst_cs_data", cs_data, 0);
    check("arst_resp_result", rif.resp_result, 0);
    check("arst_resp_err", rif.resp_err, 0);
    tick();
    rst = 1'b0;
    ptr_m = 0;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (rif.resp_valid === 1'b1) seen = 1'b1;
    end
    check("abort_no_resp", seen, 0);
    cs_lat = 2;
    set_req(0, rand_data());
    set_req(1, rand_data());
    do_txn(1'b0, 1'b0, 1'b0);
    do_txn(1'b0, 1'b0, 1'b0);

    for (int r = 0; r < 15; r++) begin
      bit [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) if (m[i]) set_req(i, rand_data());
      while (pend != '0) begin
        cs_silent = ($urandom_range(0, 5) == 0);
        cs_lat    = int'($urandom_range(1, 6));
        do_txn(1'b0, cs_silent, 1'b0);
      end
      cs_silent = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cs_req_sched.md
Name: cs_req_sched

Overview:
- Front-end scheduler for the checksum (CS) datapath; shares one CS instance among NUM_REQ requesters.
- Arbitrates round-robin and latches the winner's 512-bit data word.
- Issues a one-cycle in_valid to CS, waits for out_valid with a timeout, and returns the 16-bit result tagged with the requester id.
- Sits between requester agents and CS; CS ports connect directly to the cs_* ports.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH_DATA_1, 384, CS data field 1 width
- WIDTH_DATA_2, 128, CS data field 2 width
- WIDTH_RESULT_1, 8, CS result field 1 width
- WIDTH_RESULT_2, 8, CS result field 2 width
- TIMEOUT_CYC, 1023, max cycles waited for cs_out_valid before error

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request
- req_data  in  NUM_REQ*DW  flat data buses; DW = WIDTH_DATA_1+WIDTH_DATA_2; requester i occupies [i*DW +: DW]
- req_ready  out  NUM_REQ  one-hot accept strobe
- resp_valid  out  1  one-cycle response strobe
- resp_id  out  clog2(NUM_REQ)  id of the requester being answered
- resp_result  out  RW  CS result; RW = WIDTH_RESULT_1+WIDTH_RESULT_2
- resp_err  out  1  timeout flag
- cs_in_valid  out  1  to CS in_valid
- cs_data  out  DW  to CS data
- cs_out_valid  in  1  from CS out_valid
- cs_result  in  RW  from CS result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE, rr_ptr 0, wait counter 0
  - all registered outputs 0; cs_data 0
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = first set req_valid bit scanning from rr_ptr upward with wrap.
  - req_ready is combinational: one-hot grant only in IDLE, zero elsewhere.
  - On valid&ready: latch req_data slice into cs_data and the id into cur_id; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: cs_in_valid=1 for exactly this cycle, cs_data stable; clear counter; go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If cs_out_valid=1: latch cs_result, err=0, go to RESP.
  - Else if counter == TIMEOUT_CYC-1: result=0, err=1, go to RESP.
  - If cs_out_valid arrives on the timeout cycle, out_valid wins (err=0).
- RESP:
  - resp_valid=1 for one cycle with resp_id=cur_id, resp_result, resp_err.
  - rr_ptr <= cur_id+1, wrapping to 0 past NUM_REQ-1.
  - Go to IDLE. A new grant is possible the next cycle.
- Timing:
  - Accept at cycle T; cs_in_valid at T+1.
  - CS answering L cycles after in_valid gives resp_valid at T+L+2.
  - Minimum turnaround: 4 cycles per transaction.
- cs_out_valid outside WAIT is ignored (no state change, no response).
- cs_data holds its last value after the transaction; only cs_in_valid qualifies it.
- Requester rules:
  - A requester must hold req_valid and req_data stable until req_ready.
  - Dropping req_valid before ready is legal (request withdrawn).
  - Keeping req_valid high after ready is treated as a new request.
- Reset mid-transaction:
  - Abandons the transaction; no resp_valid is emitted.
  - CS is reset by its own rst_n, driven by the integrator.

Optional Feature:
- Macro: CS_SCHED_STAT_EN.
- Defined:
  - Adds outputs stat_done (16-bit, count of RESP with err=0) and stat_timeout (16-bit, count with err=1).
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: no extra ports or registers; behaviour otherwise identical.

Decomposition:
- Package cs_sched_pkg:
  - state enum (IDLE, ISSUE, WAIT, RESP)
  - default width localparams DW=512, RW=16
  - function for id width, clog2(NUM_REQ)
- Sub-module cs_rr_arb: combinational round-robin picker.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, encoded id, any-valid.
  - Instantiated once.

Test Plan:
- Single request: req_valid[2]=1, data=512'hA5..A5, CS model latency 3 → req_ready[2] at T, cs_in_valid at T+1, resp_valid at T+5, resp_id=2, resp_result = model result, resp_err=0.
- All four requesters assert together after reset → service order 0,1,2,3; each resp_id matches; each cs_in_valid pulse lasts exactly one cycle.
- Requesters 0 and 3 held continuously → grants alternate 0,3,0,3 across 8 transactions.
- TIMEOUT_CYC=16, CS model silent → resp_valid at T+18 with resp_err=1, resp_result=16'h0000; a following request is served normally.
- cs_out_valid pulsed in IDLE and in ISSUE → no resp_valid, state unchanged.
- rst asserted during WAIT → all outputs 0 asynchronously, no response, rr_ptr=0; the next request to requester 1 completes normally.
